// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: op codes, FSM states, widths.
package mdu_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [3:0] {
    MDU_OP_NONE  = 4'd0,
    MDU_OP_MULT  = 4'd1,
    MDU_OP_MULTU = 4'd2,
    MDU_OP_DIV   = 4'd3,
    MDU_OP_DIVU  = 4'd4,
    MDU_OP_MTHI  = 4'd5,
    MDU_OP_MTLO  = 4'd6,
    MDU_OP_MFHI  = 4'd7,
    MDU_OP_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle busy period.
  function automatic logic is_muldiv(mdu_op_e op);
    return (op == MDU_OP_MULT) || (op == MDU_OP_MULTU) ||
           (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage to MDU request/response bundle; clock and reset stay outside.
interface mdu_if;
  import mdu_pkg::*;

  logic [XLEN-1:0] iA1;
  logic [XLEN-1:0] iA2;
  mdu_op_e         iop;
  logic            istart;
  logic            obusy;
  logic [XLEN-1:0] ohi;
  logic [XLEN-1:0] olo;
  logic [XLEN-1:0] oresult;

  modport master (output iA1, iA2, iop, istart,
                  input  obusy, ohi, olo, oresult);
  modport slave  (input  iA1, iA2, iop, istart,
                  output obusy, ohi, olo, oresult);
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO; results are computed at accept
// and held in pending registers until the busy counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic iclk,
  input  logic irst_n,
  mdu_if.slave bus
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  pend_hi_q, pend_hi_d;
  logic [XLEN-1:0]  pend_lo_q, pend_lo_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;

  logic             accept_c;
  logic             last_c;
  logic [2*XLEN-1:0] res_c;
  logic [XLEN-1:0]  a_c, b_c;

  assign a_c      = bus.iA1;
  assign b_c      = bus.iA2;
  assign accept_c = bus.istart && (state_q == ST_IDLE);
  assign last_c   = (state_q == ST_BUSY) && (cnt_q == CNT_W'(1));

  // 64-bit {HI,LO} candidate for the current op, including the MIPS corner cases.
  always_comb begin
    res_c = '0;
    case (bus.iop)
      MDU_OP_MULT:
        res_c = $signed({{XLEN{a_c[XLEN-1]}}, a_c}) * $signed({{XLEN{b_c[XLEN-1]}}, b_c});
      MDU_OP_MULTU:
        res_c = {{XLEN{1'b0}}, a_c} * {{XLEN{1'b0}}, b_c};
      MDU_OP_DIV: begin
        if (b_c == '0)
          res_c = {a_c, {XLEN{1'b1}}};
        else if ((a_c == 32'h8000_0000) && (b_c == 32'hFFFF_FFFF))
          res_c = {{XLEN{1'b0}}, 32'h8000_0000};
        else
          res_c = {XLEN'($signed(a_c) % $signed(b_c)), XLEN'($signed(a_c) / $signed(b_c))};
      end
      MDU_OP_DIVU: begin
        if (b_c == '0)
          res_c = {a_c, {XLEN{1'b1}}};
        else
          res_c = {a_c % b_c, a_c / b_c};
      end
      default: res_c = '0;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c && is_muldiv(bus.iop)) state_d = ST_BUSY;
      ST_BUSY: if (last_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, pending capture, MTHI/MTLO writes and commit on the final busy edge.
  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (accept_c) begin
      case (bus.iop)
        MDU_OP_MULT, MDU_OP_MULTU: begin
          cnt_d                  = CNT_W'(MULT_CYCLES);
          {pend_hi_d, pend_lo_d} = res_c;
        end
        MDU_OP_DIV, MDU_OP_DIVU: begin
          cnt_d                  = CNT_W'(DIV_CYCLES);
          {pend_hi_d, pend_lo_d} = res_c;
        end
        MDU_OP_MTHI: hi_d = a_c;
        MDU_OP_MTLO: lo_d = a_c;
        default: ;
      endcase
    end else if (state_q == ST_BUSY) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (last_c) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end
  end

  // Outputs: busy from state, reads mux committed registers only.
  always_comb begin
    bus.obusy   = (state_q == ST_BUSY);
    bus.ohi     = hi_q;
    bus.olo     = lo_q;
    bus.oresult = '0;
    case (bus.iop)
      MDU_OP_MFHI: bus.oresult = hi_q;
      MDU_OP_MFLO: bus.oresult = lo_q;
      default:     bus.oresult = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu.sv
// Directed-vector bench for mdu: latency, results, corner cases, drops and reset abort.
module tb_mdu;
  import mdu_pkg::*;

  logic iclk;
  logic irst_n;
  mdu_if bus ();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .iclk   (iclk),
    .irst_n (irst_n),
    .bus    (bus)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    @(negedge iclk);
    bus.iop = op; bus.iA1 = a; bus.iA2 = b; bus.istart = 1'b1;
    @(negedge iclk);
    bus.istart = 1'b0; bus.iop = MDU_OP_NONE;
    bus.iA1 = 32'hDEAD_BEEF; bus.iA2 = 32'h0BAD_0BAD;
  endtask

  task automatic read_back(input string tag, input logic [31:0] eh, input logic [31:0] el);
    bus.iop = MDU_OP_MFHI; #1;
    check({tag, " mfhi"}, bus.oresult, eh);
    bus.iop = MDU_OP_MFLO; #1;
    check({tag, " mflo"}, bus.oresult, el);
    bus.iop = MDU_OP_NONE;
  endtask

  // Issue one mul/div and verify busy length, HI/LO hold, then the commit.
  task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    issue(op, a, b);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge iclk);
      check($sformatf("%s busy%0d", tag, i), 32'(bus.obusy), 32'd1);
      check($sformatf("%s hold_hi%0d", tag, i), bus.ohi, hi_m);
      check($sformatf("%s hold_lo%0d", tag, i), bus.olo, lo_m);
    end
    @(negedge iclk);
    check({tag, " idle"}, 32'(bus.obusy), 32'd0);
    check({tag, " hi"}, bus.ohi, eh);
    check({tag, " lo"}, bus.olo, el);
    read_back(tag, eh, el);
    hi_m = eh; lo_m = el;
  endtask

  initial begin
    bus.iop = MDU_OP_NONE; bus.istart = 1'b0; bus.iA1 = '0; bus.iA2 = '0;
    irst_n = 1'b0;
    #1;
    check("rst busy", 32'(bus.obusy), 32'd0);
    check("rst hi", bus.ohi, 32'd0);
    check("rst lo", bus.olo, 32'd0);
    check("rst result", bus.oresult, 32'd0);
    @(negedge iclk); @(negedge iclk);
    irst_n = 1'b1;

    run_op("mult", MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu", MDU_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div", MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu0", MDU_OP_DIVU, 32'd7, 32'd0, 10, 32'h0000_0007, 32'hFFFF_FFFF);
    run_op("div0", MDU_OP_DIV, 32'hFFFF_FFFB, 32'd0, 10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("divovf", MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu", MDU_OP_DIVU, 32'hFFFF_FFF0, 32'd3, 10, 32'h0000_0000, 32'h5555_5550);

    // Requests during busy are dropped.
    issue(MDU_OP_MULT, 32'd2, 32'd3);
    @(negedge iclk);
    bus.iop = MDU_OP_DIVU; bus.iA1 = 32'd9; bus.iA2 = 32'd2; bus.istart = 1'b1;
    @(negedge iclk);
    bus.iop = MDU_OP_MTLO; bus.iA1 = 32'd5; bus.istart = 1'b1;
    @(negedge iclk);
    bus.istart = 1'b0; bus.iop = MDU_OP_NONE;
    check("drop busy", 32'(bus.obusy), 32'd1);
    check("drop lo_hold", bus.olo, lo_m);
    @(negedge iclk);
    check("drop busy4", 32'(bus.obusy), 32'd1);
    @(negedge iclk);
    check("drop idle", 32'(bus.obusy), 32'd0);
    check("drop hi", bus.ohi, 32'd0);
    check("drop lo", bus.olo, 32'd6);
    @(negedge iclk);
    check("drop no_restart", 32'(bus.obusy), 32'd0);
    check("drop lo_kept", bus.olo, 32'd6);
    hi_m = 32'd0; lo_m = 32'd6;

    // MTHI takes effect at the next edge with no busy period.
    bus.iop = MDU_OP_MTHI; bus.iA1 = 32'hA5A5_A5A5; bus.istart = 1'b1;
    #1;
    check("mthi pre", bus.ohi, 32'd0);
    @(negedge iclk);
    bus.istart = 1'b0; bus.iop = MDU_OP_NONE;
    check("mthi hi", bus.ohi, 32'hA5A5_A5A5);
    check("mthi busy", 32'(bus.obusy), 32'd0);
    check("mthi lo", bus.olo, 32'd6);
    read_back("mthi", 32'hA5A5_A5A5, 32'd6);

    // Reset in the middle of a divide aborts it.
    issue(MDU_OP_DIV, 32'd100, 32'd7);
    @(negedge iclk);
    @(negedge iclk);
    check("abort busy_pre", 32'(bus.obusy), 32'd1);
    #2 irst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.obusy), 32'd0);
    check("abort hi", bus.ohi, 32'd0);
    check("abort lo", bus.olo, 32'd0);
    @(negedge iclk);
    irst_n = 1'b1;
    repeat (12) @(negedge iclk);
    check("abort no_commit_hi", bus.ohi, 32'd0);
    check("abort no_commit_lo", bus.olo, 32'd0);
    check("abort idle", 32'(bus.obusy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
